// File: rtl/cv32e40p_alu_div_radix.sv
// Serial radix-2^C_BITS_PER_CYC integer divider/remainder with early termination,
// kill and divide-by-zero flag; results follow RISC-V DIV/DIVU/REM/REMU.
module cv32e40p_alu_div_radix #(
  parameter int C_WIDTH        = 32,
  parameter int C_BITS_PER_CYC = 1,
  parameter int C_LOG_WIDTH    = $clog2(C_WIDTH+1)
) (
  input  logic               Clk_CI,
  input  logic               Rst_RI,
  input  logic [C_WIDTH-1:0] OpA_DI,
  input  logic [C_WIDTH-1:0] OpB_DI,
  input  logic [1:0]         OpCode_SI,
  input  logic               InVld_SI,
  output logic               InRdy_SO,
  input  logic               Kill_SI,
  input  logic               OutRdy_SI,
  output logic               OutVld_SO,
  output logic [C_WIDTH-1:0] Res_DO,
  output logic               DivZero_SO,
  output logic [1:0]         DbgState_SO
);

  // Handshake: operands transfer on an edge with InVld_SI & InRdy_SO; the result
  // transfers on an edge with OutVld_SO & OutRdy_SI. Kill_SI overrides both.
  typedef enum logic [1:0] {IDLE = 2'd0, DIVIDE = 2'd1, FINISH = 2'd2} state_e;

  localparam int                     LOG_K    = $clog2(C_BITS_PER_CYC);
  localparam logic [C_LOG_WIDTH-1:0] ONE_LW   = C_LOG_WIDTH'(1);
  localparam logic [C_LOG_WIDTH-1:0] KM1_LW   = C_LOG_WIDTH'(C_BITS_PER_CYC-1);
  localparam logic [C_LOG_WIDTH-1:0] WIDTH_LW = C_LOG_WIDTH'(C_WIDTH);

  state_e                 state_q, state_d;
  logic [C_LOG_WIDTH-1:0] cnt_q;
  logic [C_WIDTH:0]       r_q;
  logic [C_WIDTH-1:0]     q_q, b_q, a_q;
  logic                   negq_q, negr_q, rem_q, dz_q;

  logic                   accept, a_neg, b_neg, b_zero;
  logic [C_WIDTH-1:0]     abs_a, abs_b, q_load;
  logic [C_WIDTH:0]       r_load, r_step;
  logic [C_WIDTH-1:0]     q_step;
  logic [C_LOG_WIDTH-1:0] s_raw, s_rnd, s_amt, n_steps;

  function automatic logic [C_LOG_WIDTH-1:0] lzc(input logic [C_WIDTH-1:0] v);
    logic found;
    lzc   = '0;
    found = 1'b0;
    for (int i = C_WIDTH-1; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      lzc   = lzc + ONE_LW;
      end
    end
  endfunction

  assign accept = InVld_SI & InRdy_SO;

  // Skip leading dividend bits that cannot produce quotient ones.
  always_comb begin
    a_neg  = OpCode_SI[0] & OpA_DI[C_WIDTH-1];
    b_neg  = OpCode_SI[0] & OpB_DI[C_WIDTH-1];
    abs_a  = a_neg ? -OpA_DI : OpA_DI;
    abs_b  = b_neg ? -OpB_DI : OpB_DI;
    b_zero = (OpB_DI == '0);
    s_raw  = lzc(abs_b) - lzc(abs_a) + ONE_LW;
    s_rnd  = (s_raw + KM1_LW) & ~KM1_LW;
    if (s_rnd > WIDTH_LW) s_rnd = WIDTH_LW;
    s_amt   = (b_zero || (abs_a < abs_b)) ? '0 : s_rnd;
    n_steps = s_amt >> LOG_K;
    r_load  = (s_amt == WIDTH_LW) ? '0 : {1'b0, abs_a >> s_amt};
    q_load  = abs_a << (WIDTH_LW - s_amt);
  end

  always_comb begin
    r_step = r_q;
    q_step = q_q;
    for (int k = 0; k < C_BITS_PER_CYC; k++) begin
      r_step = {r_step[C_WIDTH-1:0], q_step[C_WIDTH-1]};
      q_step = {q_step[C_WIDTH-2:0], 1'b0};
      if (r_step >= {1'b0, b_q}) begin
        r_step    = r_step - {1'b0, b_q};
        q_step[0] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    InRdy_SO   = (state_q == IDLE) & ~Kill_SI & ~Rst_RI;
    OutVld_SO  = (state_q == FINISH);
    Res_DO     = '0;
    DivZero_SO = 1'b0;
    case (state_q)
      IDLE:    if (accept) state_d = (n_steps == '0) ? FINISH : DIVIDE;
      DIVIDE:  if (cnt_q == ONE_LW) state_d = FINISH;
      FINISH:  if (OutRdy_SI) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (Kill_SI) state_d = IDLE;
    if (OutVld_SO) begin
      DivZero_SO = dz_q;
      if (dz_q)       Res_DO = rem_q ? a_q : '1;
      else if (rem_q) Res_DO = negr_q ? -r_q[C_WIDTH-1:0] : r_q[C_WIDTH-1:0];
      else            Res_DO = negq_q ? -q_q : q_q;
    end
  end

  assign DbgState_SO = state_q;

  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      b_q     <= '0;
      a_q     <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      rem_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q  <= n_steps;
        r_q    <= r_load;
        q_q    <= q_load;
        b_q    <= abs_b;
        a_q    <= OpA_DI;
        negq_q <= (a_neg ^ b_neg) & ~b_zero;
        negr_q <= a_neg;
        rem_q  <= OpCode_SI[1];
        dz_q   <= b_zero;
      end else if (state_q == DIVIDE && !Kill_SI) begin
        r_q   <= r_step;
        q_q   <= q_step;
        cnt_q <= cnt_q - ONE_LW;
      end
    end
  end

endmodule

// File: tb/tb_cv32e40p_alu_div_radix.sv
// Directed bench for cv32e40p_alu_div_radix: radix-2 and radix-16 instances
// checked with hand-computed results, latencies, kill and reset behaviour.
module tb_cv32e40p_alu_div_radix;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] opa, opb;
  logic [1:0]  opc;
  logic        invld, kill, outrdy, sel4;

  logic        inrdy1, vld1, dz1, inrdy4, vld4, dz4;
  logic [31:0] res1, res4;
  logic [1:0]  st1, st4;

  logic        inrdy_o, outvld_o, dz_o;
  logic [31:0] res_o;
  logic [1:0]  st_o;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  assign inrdy_o  = sel4 ? inrdy4 : inrdy1;
  assign outvld_o = sel4 ? vld4   : vld1;
  assign dz_o     = sel4 ? dz4    : dz1;
  assign res_o    = sel4 ? res4   : res1;
  assign st_o     = sel4 ? st4    : st1;

  cv32e40p_alu_div_radix #(.C_WIDTH(32), .C_BITS_PER_CYC(1)) u_dut1 (
    .Clk_CI(clk), .Rst_RI(rst), .OpA_DI(opa), .OpB_DI(opb), .OpCode_SI(opc),
    .InVld_SI(invld & ~sel4), .InRdy_SO(inrdy1), .Kill_SI(kill),
    .OutRdy_SI(outrdy & ~sel4), .OutVld_SO(vld1), .Res_DO(res1),
    .DivZero_SO(dz1), .DbgState_SO(st1));

  cv32e40p_alu_div_radix #(.C_WIDTH(32), .C_BITS_PER_CYC(4)) u_dut4 (
    .Clk_CI(clk), .Rst_RI(rst), .OpA_DI(opa), .OpB_DI(opb), .OpCode_SI(opc),
    .InVld_SI(invld & sel4), .InRdy_SO(inrdy4), .Kill_SI(kill),
    .OutRdy_SI(outrdy & sel4), .OutVld_SO(vld4), .Res_DO(res4),
    .DivZero_SO(dz4), .DbgState_SO(st4));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic accept_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    @(negedge clk);
    opa = a; opb = b; opc = op; invld = 1'b1;
    @(posedge clk); #1;
    invld = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] op, input logic [31:0] exp_res,
                       input logic exp_dz, input int exp_n);
    int n;
    @(negedge clk);
    check({tag, " inrdy"}, {31'b0, inrdy_o}, 32'd1);
    accept_op(a, b, op);
    n = 0;
    while (!outvld_o && n < 100) begin
      if (n == 0) check({tag, " res while busy"}, res_o, 32'd0);
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, n, exp_n);
    check({tag, " res"}, res_o, exp_res);
    check({tag, " divzero"}, {31'b0, dz_o}, {31'b0, exp_dz});
    @(negedge clk);
    outrdy = 1'b1;
    @(posedge clk); #1;
    outrdy = 1'b0;
    check({tag, " outvld drop"}, {31'b0, outvld_o}, 32'd0);
  endtask

  initial begin
    logic seen;
    rst = 1'b1; opa = '0; opb = '0; opc = '0;
    invld = 1'b0; kill = 1'b0; outrdy = 1'b0; sel4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset inrdy", {31'b0, inrdy_o}, 32'd0);
    check("reset outvld", {31'b0, outvld_o}, 32'd0);
    check("reset res", res_o, 32'd0);
    check("reset dz", {31'b0, dz_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_op("udiv 100/7", 32'd100, 32'd7, 2'd0, 32'd14, 1'b0, 5);
    do_op("urem 100/7", 32'd100, 32'd7, 2'd2, 32'd2, 1'b0, 5);
    do_op("div -7/2", 32'hFFFFFFF9, 32'd2, 2'd1, 32'hFFFFFFFD, 1'b0, 2);
    do_op("rem -7/2", 32'hFFFFFFF9, 32'd2, 2'd3, 32'hFFFFFFFF, 1'b0, 2);
    do_op("div 7/-2", 32'd7, 32'hFFFFFFFE, 2'd1, 32'hFFFFFFFD, 1'b0, 2);
    do_op("udiv 5/0", 32'd5, 32'd0, 2'd0, 32'hFFFFFFFF, 1'b1, 0);
    do_op("rem -5/0", 32'hFFFFFFFB, 32'd0, 2'd3, 32'hFFFFFFFB, 1'b1, 0);
    do_op("div -5/0", 32'hFFFFFFFB, 32'd0, 2'd1, 32'hFFFFFFFF, 1'b1, 0);
    do_op("div min/-1", 32'h80000000, 32'hFFFFFFFF, 2'd1, 32'h80000000, 1'b0, 32);
    do_op("rem min/-1", 32'h80000000, 32'hFFFFFFFF, 2'd3, 32'd0, 1'b0, 32);
    do_op("udiv 3/10", 32'd3, 32'd10, 2'd0, 32'd0, 1'b0, 0);
    do_op("urem 3/10", 32'd3, 32'd10, 2'd2, 32'd3, 1'b0, 0);

    // Result must hold while the consumer stalls.
    accept_op(32'd3, 32'd10, 2'd2);
    for (int i = 0; i < 10; i++) begin
      check("hold res", res_o, 32'd3);
      check("hold outvld", {31'b0, outvld_o}, 32'd1);
      check("hold inrdy", {31'b0, inrdy_o}, 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk); outrdy = 1'b1;
    @(posedge clk); #1; outrdy = 1'b0;
    check("hold release", {31'b0, outvld_o}, 32'd0);

    // Kill on the third DIVIDE cycle.
    accept_op(32'h80000000, 32'd1, 2'd1);
    repeat (2) begin @(posedge clk); #1; end
    check("kill state divide", {30'b0, st_o}, 32'd1);
    kill = 1'b1; #1;
    check("kill inrdy gated", {31'b0, inrdy_o}, 32'd0);
    @(posedge clk); #1;
    kill = 1'b0; #1;
    check("kill idle", {30'b0, st_o}, 32'd0);
    check("kill inrdy", {31'b0, inrdy_o}, 32'd1);
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; seen = seen | outvld_o; end
    check("kill no result", {31'b0, seen}, 32'd0);
    do_op("udiv 9/3 after kill", 32'd9, 32'd3, 2'd0, 32'd3, 1'b0, 3);

    // Kill beats accept and beats OutRdy.
    @(negedge clk);
    opa = 32'd3; opb = 32'd10; opc = 2'd0; invld = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    invld = 1'b0; kill = 1'b0;
    check("kill vs accept outvld", {31'b0, outvld_o}, 32'd0);
    check("kill vs accept state", {30'b0, st_o}, 32'd0);
    accept_op(32'd3, 32'd10, 2'd2);
    check("finish before kill", {31'b0, outvld_o}, 32'd1);
    @(negedge clk); kill = 1'b1; outrdy = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0; outrdy = 1'b0;
    check("kill in finish", {31'b0, outvld_o}, 32'd0);

    // Reset mid-DIVIDE and in FINISH.
    accept_op(32'hFFFFFFFF, 32'd1, 2'd0);
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk); rst = 1'b1; #1;
    check("rst divide state", {30'b0, st_o}, 32'd0);
    check("rst divide inrdy", {31'b0, inrdy_o}, 32'd0);
    @(negedge clk); rst = 1'b0;
    accept_op(32'd3, 32'd10, 2'd2);
    @(negedge clk); rst = 1'b1; #1;
    check("rst finish outvld", {31'b0, outvld_o}, 32'd0);
    check("rst finish res", res_o, 32'd0);
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; seen = seen | outvld_o; end
    check("rst no result", {31'b0, seen}, 32'd0);

    // Radix-16 instance.
    sel4 = 1'b1;
    do_op("k4 udiv max/1", 32'hFFFFFFFF, 32'd1, 2'd0, 32'hFFFFFFFF, 1'b0, 8);
    do_op("k4 udiv 100/7", 32'd100, 32'd7, 2'd0, 32'd14, 1'b0, 2);
    do_op("k4 urem 100/7", 32'd100, 32'd7, 2'd2, 32'd2, 1'b0, 2);
    do_op("k4 div -7/2", 32'hFFFFFFF9, 32'd2, 2'd1, 32'hFFFFFFFD, 1'b0, 1);
    do_op("k4 rem min/-1", 32'h80000000, 32'hFFFFFFFF, 2'd3, 32'd0, 1'b0, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
